// File: rtl/alu_pipe_if.sv
// rtl/alu_pipe_if.sv - operand/result handshake bundle for alu_pipe
interface alu_pipe_if #(
    parameter int WIDTH = 8,
    parameter int OPW   = 4
);
    // operand issue side
    logic             in_valid;
    logic             in_ready;
    logic [OPW-1:0]   op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             c_in;
    // result write-back side
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] result;
    logic             c_out;
    logic             zero;
    logic             neg;
    logic             ovf;
    logic             err;
    logic             carry_q;

    // issue unit / write-back unit view
    modport master (
        output in_valid, op, a, b, c_in, out_ready,
        input  in_ready, out_valid, result, c_out, zero, neg, ovf, err, carry_q
    );

    // ALU view
    modport slave (
        input  in_valid, op, a, b, c_in, out_ready,
        output in_ready, out_valid, result, c_out, zero, neg, ovf, err, carry_q
    );
endinterface

// File: rtl/alu_pipe.sv
// rtl/alu_pipe.sv - two-stage valid/ready ALU with flags and sticky carry; ALU_SAT_EN adds ADDS/SUBS
module alu_pipe #(
    parameter int WIDTH = 8,
    parameter int OPW   = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    alu_pipe_if.slave   bus
);
    localparam int MSB = WIDTH - 1;

    localparam logic [OPW-1:0] OP_ADD  = OPW'(0);
    localparam logic [OPW-1:0] OP_SUB  = OPW'(1);
    localparam logic [OPW-1:0] OP_RSUB = OPW'(2);
    localparam logic [OPW-1:0] OP_OR   = OPW'(3);
    localparam logic [OPW-1:0] OP_AND  = OPW'(4);
    localparam logic [OPW-1:0] OP_ANDN = OPW'(5);
    localparam logic [OPW-1:0] OP_XOR  = OPW'(6);
    localparam logic [OPW-1:0] OP_XNOR = OPW'(7);
    localparam logic [OPW-1:0] OP_ADDC = OPW'(8);
    localparam logic [OPW-1:0] OP_SUBC = OPW'(9);
    localparam logic [OPW-1:0] OP_SHL  = OPW'(10);
    localparam logic [OPW-1:0] OP_SHR  = OPW'(11);
`ifdef ALU_SAT_EN
    localparam logic [OPW-1:0] OP_ADDS = OPW'(12);
    localparam logic [OPW-1:0] OP_SUBS = OPW'(13);
`endif

    // how the S2 result is formed from the S1 operands
    typedef enum logic [2:0] {
        K_SUM,
        K_LOGIC,
        K_SHL,
        K_SHR,
        K_SAT,
        K_ILL
    } kind_t;

    // stage 1: registered operands
    logic             r_s1_valid;
    logic [OPW-1:0]   r_s1_op;
    logic [WIDTH-1:0] r_s1_a;
    logic [WIDTH-1:0] r_s1_b;
    logic             r_s1_cin;

    // stage 2: registered result and flags
    logic             r_s2_valid;
    logic [WIDTH-1:0] r_result;
    logic             r_cout;
    logic             r_zero;
    logic             r_neg;
    logic             r_ovf;
    logic             r_err;
    logic             r_carry_q;

    // handshake
    logic             w_s2_free;
    logic             w_s1_move;
    logic             w_in_ready;

    // datapath
    kind_t            w_kind;
    logic [WIDTH-1:0] w_x;
    logic [WIDTH-1:0] w_y;
    logic             w_c;
    logic [WIDTH-1:0] w_logic;
    logic [WIDTH:0]   w_sum;
    logic             w_sum_ovf;
    logic [WIDTH-1:0] w_res;
    logic             w_cout;
    logic             w_ovf;
    logic             w_err;
    logic             w_arith;

    // S2 can take new data when empty or when its result leaves this cycle;
    // in_ready is gated by rst_n so the issuer sees no slot while in reset
    assign w_s2_free  = !r_s2_valid || bus.out_ready;
    assign w_s1_move  = r_s1_valid && w_s2_free;
    assign w_in_ready = rst_n && (!r_s1_valid || w_s2_free);

    // decode: pick effective adder operands, carry-in and result source
    always_comb begin
        w_kind  = K_ILL;
        w_x     = r_s1_a;
        w_y     = r_s1_b;
        w_c     = r_s1_cin;
        w_logic = '0;
        case (r_s1_op)
            OP_ADD:  w_kind = K_SUM;
            OP_SUB:  begin w_kind = K_SUM; w_y = ~r_s1_b; end
            OP_RSUB: begin w_kind = K_SUM; w_x = ~r_s1_a; w_c = ~r_s1_cin; end
            OP_OR:   begin w_kind = K_LOGIC; w_logic = r_s1_a | r_s1_b; end
            OP_AND:  begin w_kind = K_LOGIC; w_logic = r_s1_a & r_s1_b; end
            OP_ANDN: begin w_kind = K_LOGIC; w_logic = ~r_s1_a & r_s1_b; end
            OP_XOR:  begin w_kind = K_LOGIC; w_logic = r_s1_a ^ r_s1_b; end
            OP_XNOR: begin w_kind = K_LOGIC; w_logic = r_s1_a ~^ r_s1_b; end
            OP_ADDC: begin w_kind = K_SUM; w_c = r_carry_q; end
            OP_SUBC: begin w_kind = K_SUM; w_y = ~r_s1_b; w_c = r_carry_q; end
            OP_SHL:  w_kind = K_SHL;
            OP_SHR:  w_kind = K_SHR;
`ifdef ALU_SAT_EN
            OP_ADDS: begin w_kind = K_SAT; w_c = 1'b0; end
            OP_SUBS: begin w_kind = K_SAT; w_y = ~r_s1_b; w_c = 1'b1; end
`endif
            default: w_kind = K_ILL;
        endcase
    end

    // one shared WIDTH+1-bit adder serves every sum-based opcode
    assign w_sum     = {1'b0, w_x} + {1'b0, w_y} + (WIDTH+1)'(w_c);
    assign w_sum_ovf = (w_x[MSB] == w_y[MSB]) && (w_sum[MSB] != w_x[MSB]);

    // result and flag selection for the value entering S2
    always_comb begin
        w_res   = '0;
        w_cout  = 1'b0;
        w_ovf   = 1'b0;
        w_err   = 1'b0;
        w_arith = 1'b0;
        case (w_kind)
            K_SUM: begin
                w_res   = w_sum[MSB:0];
                w_cout  = w_sum[WIDTH];
                w_ovf   = w_sum_ovf;
                w_arith = 1'b1;
            end
            K_LOGIC: w_res = w_logic;
            K_SHL: begin
                w_res   = {r_s1_a[MSB-1:0], 1'b0};
                w_cout  = r_s1_a[MSB];
                w_arith = 1'b1;
            end
            K_SHR: begin
                w_res   = {1'b0, r_s1_a[MSB:1]};
                w_cout  = r_s1_a[0];
                w_arith = 1'b1;
            end
`ifdef ALU_SAT_EN
            // clamp toward the sign of A: overflow only happens when A and
            // the effective B share a sign, so A's sign is the true sign
            K_SAT: begin
                w_cout  = w_sum[WIDTH];
                w_ovf   = w_sum_ovf;
                w_arith = 1'b1;
                if (w_sum_ovf) begin
                    w_res = w_x[MSB] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
                end else begin
                    w_res = w_sum[MSB:0];
                end
            end
`endif
            default: w_err = 1'b1;
        endcase
    end

    // stage 1 capture whenever a slot is offered; data is don't-care when not valid
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1_valid <= 1'b0;
            r_s1_op    <= '0;
            r_s1_a     <= '0;
            r_s1_b     <= '0;
            r_s1_cin   <= 1'b0;
        end else if (w_in_ready) begin
            r_s1_valid <= bus.in_valid;
            r_s1_op    <= bus.op;
            r_s1_a     <= bus.a;
            r_s1_b     <= bus.b;
            r_s1_cin   <= bus.c_in;
        end
    end

    // stage 2 result register; holds steady while the consumer stalls
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s2_valid <= 1'b0;
            r_result   <= '0;
            r_cout     <= 1'b0;
            r_zero     <= 1'b0;
            r_neg      <= 1'b0;
            r_ovf      <= 1'b0;
            r_err      <= 1'b0;
        end else if (w_s2_free) begin
            r_s2_valid <= r_s1_valid;
            if (r_s1_valid) begin
                r_result <= w_res;
                r_cout   <= w_cout;
                r_zero   <= (w_res == '0);
                r_neg    <= w_res[MSB];
                r_ovf    <= w_ovf;
                r_err    <= w_err;
            end
        end
    end

    // sticky carry updates at the same S1->S2 move where ADDC/SUBC read it,
    // so chained words stay in program order without a bubble
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_carry_q <= 1'b0;
        end else if (w_s1_move && w_arith) begin
            r_carry_q <= w_cout;
        end
    end

    assign bus.in_ready  = w_in_ready;
    assign bus.out_valid = r_s2_valid;
    assign bus.result    = r_result;
    assign bus.c_out     = r_cout;
    assign bus.zero      = r_zero;
    assign bus.neg       = r_neg;
    assign bus.ovf       = r_ovf;
    assign bus.err       = r_err;
    assign bus.carry_q   = r_carry_q;
endmodule

// File: tb/tb_alu_pipe.sv
// tb/tb_alu_pipe.sv - scoreboard bench for alu_pipe (WIDTH=8)
module tb_alu_pipe;
    logic clk;
    logic rst_n;

    alu_pipe_if #(.WIDTH(8), .OPW(4)) bus ();

    alu_pipe #(.WIDTH(8), .OPW(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          n_cmp = 0;
    int          n_bad = 0;
    int          n_rx  = 0;
    int          n_tx  = 0;
    int          cyc   = 0;
    int          stall_start = -100;
    int          stall_len   = 0;
    bit          rand_ready  = 0;
    bit          saw_bp      = 0;
    logic        m_carry     = 1'b0;
    logic [12:0] sb[$];
    logic [12:0] obs;
    logic [12:0] hold_obs;
    bit          hold_v = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic int sx(input int v);
        return (v >= 128) ? v - 256 : v;
    endfunction

    // reference model: {err, ovf, neg, zero, c_out, result[7:0]}; sticky carry in program order
    function automatic logic [12:0] model(input int op, input int a, input int b, input int cin);
        int   x, y, c, s, sv;
        logic [7:0] r;
        logic co, ov, er;
        bit   sum_op;
        r = 8'h00; co = 1'b0; ov = 1'b0; er = 1'b0; sum_op = 0;
        x = a; y = b; c = cin;
        case (op)
            0: sum_op = 1;
            1: begin sum_op = 1; y = 255 - b; end
            2: begin sum_op = 1; x = 255 - a; c = 1 - cin; end
            3: r = 8'(a | b);
            4: r = 8'(a & b);
            5: r = 8'((255 - a) & b);
            6: r = 8'(a ^ b);
            7: r = 8'(255 - (a ^ b));
            8: begin sum_op = 1; c = int'(m_carry); end
            9: begin sum_op = 1; y = 255 - b; c = int'(m_carry); end
            10: begin r = 8'((a * 2) % 256); co = (a >= 128); m_carry = co; end
            11: begin r = 8'(a / 2); co = (a % 2 == 1); m_carry = co; end
`ifdef ALU_SAT_EN
            12, 13: begin
                y  = (op == 12) ? b : 255 - b;
                c  = (op == 12) ? 0 : 1;
                s  = x + y + c;
                sv = sx(x) + sx(y) + c;
                co = (s >= 256);
                if (sv > 127)       begin r = 8'h7F; ov = 1'b1; end
                else if (sv < -128) begin r = 8'h80; ov = 1'b1; end
                else                r = 8'(s % 256);
                m_carry = co;
            end
`endif
            default: er = 1'b1;
        endcase
        if (sum_op) begin
            s  = x + y + c;
            sv = sx(x) + sx(y) + c;
            r  = 8'(s % 256);
            co = (s >= 256);
            ov = (sv > 127) || (sv < -128);
            m_carry = co;
        end
        return {er, ov, r[7], (r == 8'h00), co, r};
    endfunction

    // issue one transaction, waiting out back-pressure; expectation queued at acceptance
    task automatic send(input int op, input int a, input int b, input int cin);
        int guard;
        guard = 0;
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.op   = 4'(op);
        bus.a    = 8'(a);
        bus.b    = 8'(b);
        bus.c_in = cin[0];
        #1;
        while (!bus.in_ready && guard < 60) begin
            saw_bp = 1;
            @(negedge clk);
            #1;
            guard++;
        end
        if (!bus.in_ready) chk("in_ready_timeout", 0, 1);
        else begin
            sb.push_back(model(op, a, b, cin));
            n_tx++;
        end
    endtask

    task automatic idle();
        @(negedge clk);
        bus.in_valid = 1'b0;
    endtask

    task automatic drain();
        int g;
        g = 0;
        while (sb.size() != 0 && g < 120) begin
            @(negedge clk);
            g++;
        end
        chk("drain", sb.size(), 0);
        @(negedge clk);
        #3;
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // consumer: fixed stall window or random ready
    always @(negedge clk) begin
        if (rand_ready) bus.out_ready = 1'($urandom_range(0, 1));
        else bus.out_ready = !(cyc >= stall_start && cyc < stall_start + stall_len);
    end

    // monitor: hold-stability during stalls, then pop/compare on each transfer
    always @(negedge clk) begin
        #2;
        if (!rst_n) begin
            hold_v = 0;
        end else begin
            obs = {bus.err, bus.ovf, bus.neg, bus.zero, bus.c_out, bus.result};
            if (hold_v) chk("hold", {bus.out_valid, obs}, {1'b1, hold_obs});
            hold_v = 0;
            if (bus.out_valid && bus.out_ready) begin
                n_rx++;
                if (sb.size() == 0) chk("unexpected_out", 1, 0);
                else chk("result", obs, sb.pop_front());
            end else if (bus.out_valid) begin
                hold_v   = 1;
                hold_obs = obs;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int rx0;
        bus.in_valid = 1'b0;
        bus.op = '0; bus.a = '0; bus.b = '0; bus.c_in = 1'b0;
        bus.out_ready = 1'b1;
        rst_n = 1'b1;
        #2 rst_n = 1'b0;
        #1;
        chk("rst_in_ready", bus.in_ready, 0);
        repeat (2) @(posedge clk);
        #1;
        chk("rst_out_valid", bus.out_valid, 0);
        chk("rst_flags", {bus.result, bus.c_out, bus.zero, bus.neg, bus.ovf, bus.err, bus.carry_q}, 0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("post_rst_in_ready", bus.in_ready, 1);

        // ADD FF+01 with latency check
        send(0, 8'hFF, 8'h01, 0);
        @(posedge clk); #1;
        chk("lat_edge1", bus.out_valid, 0);
        @(negedge clk);
        bus.in_valid = 1'b0;
        @(posedge clk); #1;
        chk("lat_edge2", bus.out_valid, 1);
        drain();
        chk("carry_after_add", bus.carry_q, 1);

        // back-to-back 16-bit chain
        send(0, 8'hFF, 8'h01, 0);
        send(8, 8'h00, 8'h00, 0);
        idle();
        drain();
        chk("carry_after_addc", bus.carry_q, 0);

        // signed-overflow subtract and logic/shift mix
        send(1, 8'h80, 8'h01, 1);
        send(2, 8'h10, 8'h05, 0);
        send(6, 8'hA5, 8'hA5, 0);
        send(5, 8'h0F, 8'h3C, 0);
        send(7, 8'h0F, 8'h3C, 0);
        send(10, 8'h81, 8'h00, 0);
        send(11, 8'h01, 8'h00, 0);
        send(9, 8'h05, 8'h07, 0);
        idle();
        drain();

        // illegal opcode keeps carry
        send(0, 8'hFF, 8'h01, 0);
        send(14, 8'h05, 8'h03, 1);
        idle();
        drain();
        chk("carry_after_illegal", bus.carry_q, 1);

        // 12/13: saturating when enabled, illegal otherwise
        send(12, 8'h70, 8'h20, 1);
        send(13, 8'h80, 8'h01, 0);
        send(12, 8'h10, 8'h20, 0);
        idle();
        drain();
        chk("carry_after_sat", bus.carry_q, m_carry);

        // six ops with a 3-cycle consumer stall mid-stream
        saw_bp = 0;
        rx0 = n_rx;
        stall_start = cyc + 3;
        stall_len = 3;
        for (int i = 0; i < 6; i++) send(i % 3, 16 * i + 3, i + 1, i % 2);
        idle();
        drain();
        chk("stall_backpressure", saw_bp, 1);
        chk("stall_count", n_rx - rx0, 6);
        stall_start = -100;

        // random ops under random consumer ready
        rand_ready = 1;
        for (int i = 0; i < 24; i++)
            send($urandom_range(0, 15), $urandom_range(0, 255), $urandom_range(0, 255), $urandom_range(0, 1));
        idle();
        drain();
        rand_ready = 0;
        @(negedge clk);

        // reset with two transactions in flight
        send(0, 8'h11, 8'h22, 0);
        send(0, 8'hFF, 8'h01, 0);
        @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        chk("midrst_out_valid", bus.out_valid, 0);
        chk("midrst_flags", {bus.result, bus.c_out, bus.zero, bus.neg, bus.ovf, bus.err, bus.carry_q}, 0);
        chk("midrst_in_ready", bus.in_ready, 0);
        bus.in_valid = 1'b0;
        sb.delete();
        m_carry = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("midrst_release_in_ready", bus.in_ready, 1);
        send(0, 3, 4, 0);
        idle();
        drain();
        chk("sb_empty_end", sb.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
